// File: rtl/soc_mem_arbiter_pkg.sv
// Shared definitions for soc_mem_arbiter: arbitration states, slot owners and the
// saturating increment used by the optional statistics counters.
package soc_mem_arbiter_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } owner_e;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    sat_inc = (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/soc_mem_arbiter_stats.sv
// soc_arb_stats: saturating DMA-grant and CPU-stall counters for soc_mem_arbiter.
// Compiled only when ARB_STATS_EN is defined; cleared by reset_n alone.
`ifdef ARB_STATS_EN
module soc_arb_stats
  import soc_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dma_gnt,
  input  logic              cpu_rdy,
  output logic [STAT_W-1:0] stat_dma_cnt,
  output logic [STAT_W-1:0] stat_stall_cnt
);

  // Count granted DMA accesses and stalled CPU cycles, sticking at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_dma_cnt   <= {STAT_W{1'b0}};
      stat_stall_cnt <= {STAT_W{1'b0}};
    end else begin
      if (dma_gnt) begin
        stat_dma_cnt <= sat_inc(stat_dma_cnt);
      end
      if (!cpu_rdy) begin
        stat_stall_cnt <= sat_inc(stat_stall_cnt);
      end
    end
  end

endmodule
`endif

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: shares the single-port RAM between the 6502 core (priority) and a DMA
// requester with bounded slots. Defining ARB_STATS_EN adds grant/stall statistic outputs.
module soc_mem_arbiter
  import soc_mem_arbiter_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int CPU_BURST = 8,
  parameter int DMA_BURST = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_dout,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_rdy,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic          dma_we,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_dma_cnt,
  output logic [STAT_W-1:0] stat_stall_cnt
`endif
);

  localparam int CW  = (CPU_BURST > 1) ? $clog2(CPU_BURST) : 1;
  localparam int DCW = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;
  localparam logic [CW-1:0]  CPU_LAST = CW'(CPU_BURST - 1);
  localparam logic [DCW-1:0] DMA_LAST = DCW'(DMA_BURST - 1);

  arb_state_e     state_r, state_nxt_s;
  logic [CW-1:0]  cpu_cnt_r, cpu_cnt_nxt_s;
  logic [DCW-1:0] dma_cnt_r, dma_cnt_nxt_s;
  owner_e         owner_r;
  logic [DW-1:0]  hold_r;
  logic           dma_rvalid_r;
  logic           mem_we_s;

  // Next-state, burst counters and the RAM mux, all decided by the current owner.
  always_comb begin
    state_nxt_s   = state_r;
    cpu_cnt_nxt_s = cpu_cnt_r;
    dma_cnt_nxt_s = dma_cnt_r;
    mem_addr      = cpu_addr;
    mem_wdata     = cpu_dout;
    mem_we_s      = cpu_we;
    cpu_rdy       = 1'b1;
    dma_gnt       = 1'b0;
    case (state_r)
      S_CPU: begin
        if (!dma_req) begin
          cpu_cnt_nxt_s = {CW{1'b0}};
        end else if (cpu_cnt_r == CPU_LAST) begin
          state_nxt_s   = S_DMA;
          cpu_cnt_nxt_s = {CW{1'b0}};
        end else begin
          cpu_cnt_nxt_s = cpu_cnt_r + CW'(1);
        end
      end
      S_DMA: begin
        mem_addr  = dma_addr;
        mem_wdata = dma_wdata;
        mem_we_s  = dma_we & dma_req;
        cpu_rdy   = 1'b0;
        dma_gnt   = dma_req;
        // A dropped request wastes this slot and hands the RAM straight back.
        if (!dma_req || (dma_cnt_r == DMA_LAST)) begin
          state_nxt_s   = S_CPU;
          dma_cnt_nxt_s = {DCW{1'b0}};
        end else begin
          dma_cnt_nxt_s = dma_cnt_r + DCW'(1);
        end
      end
      default: begin
        state_nxt_s   = S_CPU;
        cpu_cnt_nxt_s = {CW{1'b0}};
        dma_cnt_nxt_s = {DCW{1'b0}};
      end
    endcase
  end

  assign mem_we = mem_we_s & reset_n;

  // Arbitration state and burst counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= S_CPU;
      cpu_cnt_r <= {CW{1'b0}};
      dma_cnt_r <= {DCW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cpu_cnt_r <= cpu_cnt_nxt_s;
      dma_cnt_r <= dma_cnt_nxt_s;
    end
  end

  // Read-data steering: remember who owned the RAM last cycle and freeze the core's data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_r      <= OWNER_CPU;
      hold_r       <= {DW{1'b0}};
      dma_rvalid_r <= 1'b0;
    end else begin
      owner_r      <= (state_r == S_CPU) ? OWNER_CPU : OWNER_DMA;
      dma_rvalid_r <= dma_gnt & ~dma_we;
      if (owner_r == OWNER_CPU) begin
        hold_r <= mem_rdata;
      end
    end
  end

  assign cpu_din    = (owner_r == OWNER_CPU) ? mem_rdata : hold_r;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = dma_rvalid_r;

`ifdef ARB_STATS_EN
  soc_arb_stats u_stats (
    .clk            (clk),
    .reset_n        (reset_n),
    .dma_gnt        (dma_gnt),
    .cpu_rdy        (cpu_rdy),
    .stat_dma_cnt   (stat_dma_cnt),
    .stat_stall_cnt (stat_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Self-checking bench for soc_mem_arbiter (CPU_BURST=4, DMA_BURST=2): slot-level model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_soc_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int CPU_BURST = 4;
  localparam int DMA_BURST = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_dout, cpu_din, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
  logic          cpu_we, cpu_rdy, dma_req, dma_we, dma_gnt, dma_rvalid, mem_we;
`ifdef ARB_STATS_EN
  logic [15:0]   stat_dma_cnt, stat_stall_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  soc_mem_arbiter #(.AW(AW), .DW(DW), .CPU_BURST(CPU_BURST), .DMA_BURST(DMA_BURST)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we), .cpu_din(cpu_din),
    .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_we(dma_we),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_dma_cnt(stat_dma_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  // Environment RAM: synchronous, one-cycle read latency, read-before-write.
  logic [7:0] ram [0:65535];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    ram_q <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Slot-level model: who owns each cycle, what the core last read, what DMA reads return.
  logic [7:0] mdl_mem [0:65535];
  bit         m_dma_slot;
  int         m_cpu_run, m_dma_run;
  logic [7:0] m_cpu_din;
  bit         m_rvalid;
  logic [7:0] m_rdata;

  initial begin
    m_dma_slot = 0; m_cpu_run = 0; m_dma_run = 0; m_rvalid = 0; m_cpu_din = 8'h00;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_dma_slot = 0; m_cpu_run = 0; m_dma_run = 0; m_rvalid = 0;
        if (clk) m_cpu_din = mdl_mem[cpu_addr];
      end else if (!m_dma_slot) begin
        m_cpu_din = mdl_mem[cpu_addr];
        m_rvalid = 0;
        if (cpu_we) mdl_mem[cpu_addr] = cpu_dout;
        if (dma_req) begin
          m_cpu_run++;
          if (m_cpu_run >= CPU_BURST) begin m_dma_slot = 1; m_cpu_run = 0; end
        end else m_cpu_run = 0;
      end else begin
        m_rvalid = dma_req && !dma_we;
        if (m_rvalid) m_rdata = mdl_mem[dma_addr];
        if (dma_req && dma_we) mdl_mem[dma_addr] = dma_wdata;
        if (dma_req) m_dma_run++;
        if (!dma_req || m_dma_run >= DMA_BURST) begin m_dma_slot = 0; m_dma_run = 0; end
      end
    end
  end

  // Compare DUT outputs against the model every cycle, mid-cycle.
  initial begin
    bit exp_we;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_cpu_rdy", cpu_rdy, 1);
        chk("rst_dma_gnt", dma_gnt, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_mem_we", mem_we, 0);
      end else begin
        exp_we = m_dma_slot ? (dma_req && dma_we) : cpu_we;
        chk("cpu_rdy", cpu_rdy, !m_dma_slot);
        chk("dma_gnt", dma_gnt, m_dma_slot && dma_req);
        chk("mem_addr", mem_addr, m_dma_slot ? dma_addr : cpu_addr);
        chk("mem_we", mem_we, exp_we);
        if (exp_we) chk("mem_wdata", mem_wdata, m_dma_slot ? dma_wdata : cpu_dout);
        chk("cpu_din", cpu_din, m_cpu_din);
        chk("dma_rvalid", dma_rvalid, m_rvalid);
        if (m_rvalid) chk("dma_rdata", dma_rdata, m_rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    cpu_we = 1'b0; dma_req = 1'b0; dma_we = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(); go_idle(); step();
    reset_n = 1'b1;
  endtask

  task automatic wait_gnt(output bit got);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (dma_gnt) got = 1;
      else step();
    end
  endtask

  initial begin
    logic [11:0] pat;
    bit got;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'(i ^ (i >> 8));
      mdl_mem[i] = 8'(i ^ (i >> 8));
    end
    ram[16'h1234] = 8'hA5; mdl_mem[16'h1234] = 8'hA5;
    ram[16'h0300] = 8'h3C; mdl_mem[16'h0300] = 8'h3C;
    // Busy inputs during power-on reset: mem_we must still stay low.
    cpu_addr = 16'h0010; cpu_dout = 8'hEE; cpu_we = 1'b1;
    dma_addr = 16'h0300; dma_wdata = 8'hDD; dma_we = 1'b1; dma_req = 1'b1;
    repeat (3) step();
    go_idle();
    step();
    reset_n = 1'b1;

    // Continuous DMA demand: 4 CPU slots, 2 DMA slots, repeating.
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300; cpu_addr = 16'h0010;
    pat = 12'h000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      pat = {pat[10:0], cpu_rdy};
      step();
    end
    chk("burst_pattern", pat, 12'b111100111100);

    // DMA write then CPU read of the same byte; the dropped request wastes one slot.
    do_reset();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 8'h5A;
    wait_gnt(got);
    chk("dma_wr_gnt_seen", got, 1);
    step();
    dma_req = 1'b0; dma_we = 1'b0; cpu_addr = 16'h0200;
    @(negedge clk);
    chk("wasted_slot_rdy", cpu_rdy, 0);
    chk("wasted_slot_we", mem_we, 0);
    step();
    @(negedge clk);
    chk("cpu_back_rdy", cpu_rdy, 1);
    step();
    @(negedge clk);
    chk("dma_wr_cpu_rd", cpu_din, 8'h5A);

    // CPU read on its last slot is held across the stall; DMA read returns one cycle later.
    do_reset();
    cpu_addr = 16'h0010; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
    repeat (3) step();
    cpu_addr = 16'h1234;
    @(negedge clk);
    chk("last_cpu_slot_rdy", cpu_rdy, 1);
    step();
    @(negedge clk);
    chk("stall1_rdy", cpu_rdy, 0);
    chk("stall1_gnt", dma_gnt, 1);
    chk("stall1_din", cpu_din, 8'hA5);
    step();
    @(negedge clk);
    chk("stall2_rdy", cpu_rdy, 0);
    chk("stall2_din", cpu_din, 8'hA5);
    chk("dma_rd_rvalid", dma_rvalid, 1);
    chk("dma_rd_rdata", dma_rdata, 8'h3C);
    step();
    @(negedge clk);
    chk("resume_rdy", cpu_rdy, 1);
    chk("resume_din", cpu_din, 8'hA5);

    // Reset pulsed in the middle of a DMA burst.
    do_reset();
    cpu_addr = 16'h0010; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
    wait_gnt(got);
    chk("dma_rd_gnt_seen", got, 1);
    step();
    @(negedge clk);
    chk("pre_rst_rvalid", dma_rvalid, 1);
`ifdef ARB_STATS_EN
    chk("pre_rst_stat_dma", stat_dma_cnt, 16'd1);
    chk("pre_rst_stat_stall", stat_stall_cnt, 16'd1);
`endif
    #1 reset_n = 1'b0;
    #1;
    chk("mid_dma_rst_rdy", cpu_rdy, 1);
    chk("mid_dma_rst_rvalid", dma_rvalid, 0);
    chk("mid_dma_rst_gnt", dma_gnt, 0);
`ifdef ARB_STATS_EN
    chk("rst_stat_dma", stat_dma_cnt, 16'd0);
    chk("rst_stat_stall", stat_stall_cnt, 16'd0);
`endif
    step(); go_idle(); step();
    reset_n = 1'b1;

    // Mixed traffic on a shared address window, checked by the model every cycle.
    for (int c = 0; c < 40; c++) begin
      cpu_addr  = 16'h0400 + 16'(c & 7);
      cpu_dout  = 8'(c * 7 + 1);
      cpu_we    = ((c % 3) == 0);
      dma_req   = ((c % 11) < 7);
      dma_we    = ((c % 4) < 2);
      dma_addr  = 16'h0400 + 16'((c * 3) & 7);
      dma_wdata = 8'(8'h80 + c);
      step();
    end
    go_idle();
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
